// File: rtl/canny_frame_ctrl_pkg.sv
// Shared types and sizing helpers for the Canny frame sequencer.
// The DEF_* values mirror the default top-level parameters.
package canny_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, VBLK, LINE, HBLK, FLUSH, DRAIN, DONE} state_e;

   localparam int DEF_H_RES   = 80;
   localparam int DEF_V_RES   = 60;
   localparam int DEF_H_BLANK = 16;
   localparam int FRAME_PIX   = DEF_H_RES * DEF_V_RES;
   localparam int LINE_PERIOD = DEF_H_RES + DEF_H_BLANK;

   function automatic int frame_pix(input int h_res, input int v_res);
      return h_res * v_res;
   endfunction

   function automatic int line_period(input int h_res, input int h_blank);
      return h_res + h_blank;
   endfunction

endpackage

// File: rtl/canny_frame_ctrl_if.sv
// Bus bundle between the frame sequencer and its RAMs / edge engine.
// The master side belongs to the sequencer; the slave side to the environment.
interface canny_frame_ctrl_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 13
);
   logic              src_rd_en;
   logic [ADDR_W-1:0] src_rd_addr;
   logic [WIDTH-1:0]  src_rd_data;
   logic              c_vsync;
   logic              c_hsync;
   logic              c_de;
   logic [WIDTH-1:0]  c_data;
   logic              e_vsync;
   logic              e_hsync;
   logic              e_de;
   logic [WIDTH-1:0]  e_data;
   logic              dst_wr_en;
   logic [ADDR_W-1:0] dst_wr_addr;
   logic [WIDTH-1:0]  dst_wr_data;

   modport master (
      output src_rd_en, src_rd_addr, input src_rd_data,
      output c_vsync, c_hsync, c_de, c_data,
      input  e_vsync, e_hsync, e_de, e_data,
      output dst_wr_en, dst_wr_addr, dst_wr_data
   );

   modport slave (
      input  src_rd_en, src_rd_addr, output src_rd_data,
      input  c_vsync, c_hsync, c_de, c_data,
      output e_vsync, e_hsync, e_de, e_data,
      input  dst_wr_en, dst_wr_addr, dst_wr_data
   );
endinterface

// File: rtl/canny_frame_ctrl_capture_wr.sv
// Captures edge-engine output beats into the destination RAM, one frame's worth;
// beats beyond the frame size are flush residue and are dropped.
module canny_capture_wr #(
   parameter int WIDTH     = 8,
   parameter int ADDR_W    = 13,
   parameter int FRAME_PIX = 4800
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clear,
   input  logic              enable,
   input  logic              e_de,
   input  logic [WIDTH-1:0]  e_data,
   output logic              dst_wr_en,
   output logic [ADDR_W-1:0] dst_wr_addr,
   output logic [WIDTH-1:0]  dst_wr_data,
   output logic              full
);
   localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W+1)'(FRAME_PIX);

   logic [ADDR_W:0] wr_cnt;

   assign full = (wr_cnt == PIX_LIMIT);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_cnt      <= '0;
         dst_wr_en   <= 1'b0;
         dst_wr_addr <= '0;
         dst_wr_data <= '0;
      end else if (clear) begin
         wr_cnt    <= '0;
         dst_wr_en <= 1'b0;
      end else if (enable && e_de && (wr_cnt < PIX_LIMIT)) begin
         dst_wr_en   <= 1'b1;
         dst_wr_addr <= wr_cnt[ADDR_W-1:0];
         dst_wr_data <= e_data;
         wr_cnt      <= wr_cnt + 1'b1;
      end else begin
         dst_wr_en <= 1'b0;
      end
   end
endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for the Canny edge stage: streams a source frame with video
// timing, feeds flush lines to drain the line buffers, and captures the result.
module canny_frame_ctrl
   import canny_ctrl_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int H_RES       = 80,
   parameter int V_RES       = 60,
   parameter int H_BLANK     = 16,
   parameter int V_BLANK     = 2,
   parameter int FLUSH_LINES = 3,
   parameter int ADDR_W      = 13,
   parameter int TIMEOUT     = 65535
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [15:0]        frame_cnt,
   canny_frame_ctrl_if.master bus
);
   localparam int FPIX      = frame_pix(H_RES, V_RES);
   localparam int LPER      = line_period(H_RES, H_BLANK);
   localparam int MAX_LINES = (V_BLANK > FLUSH_LINES) ? V_BLANK : FLUSH_LINES;
   localparam int CNT_W     = $clog2(LPER + 1);
   localparam int ROW_W     = $clog2(V_RES + 1);
   localparam int LN_W      = $clog2(MAX_LINES + 1);
   localparam int TMO_W     = $clog2(TIMEOUT + 1);

   state_e            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [ROW_W-1:0]  row, row_nx;
   logic [LN_W-1:0]   lines, lines_nx;
   logic [ADDR_W-1:0] rd_addr, rd_addr_nx;
   logic [TMO_W-1:0]  tmo, tmo_nx;
   logic              error_nx;
   logic [15:0]       frame_cnt_nx;
   logic              cap_clr, cap_en, frame_full;
   logic              de1, flush1, vs1, hs1;
   logic              unused_sync;

   // lines counts vblank periods, then is reused to count flush lines
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      row_nx       = row;
      lines_nx     = lines;
      rd_addr_nx   = rd_addr;
      tmo_nx       = tmo;
      error_nx     = error;
      frame_cnt_nx = frame_cnt;
      cap_clr      = 1'b0;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: if (start) begin
               state_nx   = VBLK;
               error_nx   = 1'b0;
               cnt_nx     = '0;
               row_nx     = '0;
               lines_nx   = '0;
               rd_addr_nx = '0;
               cap_clr    = 1'b1;
            end
            VBLK: begin
               cnt_nx = cnt + 1'b1;
               if (cnt == CNT_W'(LPER - 1)) begin
                  cnt_nx = '0;
                  if (lines == LN_W'(V_BLANK - 1)) begin
                     lines_nx = '0;
                     state_nx = LINE;
                  end else begin
                     lines_nx = lines + 1'b1;
                  end
               end
            end
            LINE: begin
               cnt_nx     = cnt + 1'b1;
               rd_addr_nx = rd_addr + 1'b1;
               if (cnt == CNT_W'(H_RES - 1)) begin
                  cnt_nx   = '0;
                  state_nx = HBLK;
               end
            end
            FLUSH: begin
               cnt_nx = cnt + 1'b1;
               if (cnt == CNT_W'(H_RES - 1)) begin
                  cnt_nx   = '0;
                  lines_nx = lines + 1'b1;
                  state_nx = HBLK;
               end
            end
            HBLK: begin
               cnt_nx = cnt + 1'b1;
               if (cnt == CNT_W'(H_BLANK - 1)) begin
                  cnt_nx = '0;
                  if (row < ROW_W'(V_RES - 1)) begin
                     row_nx   = row + 1'b1;
                     state_nx = LINE;
                  end else if (lines < LN_W'(FLUSH_LINES)) begin
                     state_nx = FLUSH;
                  end else begin
                     tmo_nx   = '0;
                     state_nx = DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (frame_full) begin
                  state_nx     = DONE;
                  frame_cnt_nx = frame_cnt + 16'd1;
               end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                  error_nx = 1'b1;
                  state_nx = IDLE;
               end else begin
                  tmo_nx = tmo + 1'b1;
               end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         row       <= '0;
         lines     <= '0;
         rd_addr   <= '0;
         tmo       <= '0;
         error     <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         row       <= row_nx;
         lines     <= lines_nx;
         rd_addr   <= rd_addr_nx;
         tmo       <= tmo_nx;
         error     <= error_nx;
         frame_cnt <= frame_cnt_nx;
      end
   end

   assign busy            = (state != IDLE);
   assign done            = (state == DONE);
   assign bus.src_rd_en   = (state == LINE);
   assign bus.src_rd_addr = (state == LINE) ? rd_addr : '0;
   assign cap_en          = busy && (state != DONE) && !abort;
   assign unused_sync     = bus.e_vsync ^ bus.e_hsync;

   // Two stages so the pixel lines up with RAM data that returns one cycle after the read
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         de1         <= 1'b0;
         flush1      <= 1'b0;
         vs1         <= 1'b0;
         hs1         <= 1'b0;
         bus.c_de    <= 1'b0;
         bus.c_vsync <= 1'b0;
         bus.c_hsync <= 1'b0;
         bus.c_data  <= '0;
      end else if (abort) begin
         de1         <= 1'b0;
         flush1      <= 1'b0;
         vs1         <= 1'b0;
         hs1         <= 1'b0;
         bus.c_de    <= 1'b0;
         bus.c_vsync <= 1'b0;
         bus.c_hsync <= 1'b0;
         bus.c_data  <= '0;
      end else begin
         de1         <= (state == LINE) || (state == FLUSH);
         flush1      <= (state == FLUSH);
         vs1         <= (state == VBLK);
         hs1         <= (state == HBLK);
         bus.c_de    <= de1;
         bus.c_vsync <= vs1;
         bus.c_hsync <= hs1;
         bus.c_data  <= (de1 && !flush1) ? bus.src_rd_data : '0;
      end
   end

   canny_capture_wr #(
      .WIDTH     (WIDTH),
      .ADDR_W    (ADDR_W),
      .FRAME_PIX (FPIX)
   ) u_capture (
      .clk         (clk),
      .rstn        (rstn),
      .clear       (cap_clr),
      .enable      (cap_en),
      .e_de        (bus.e_de),
      .e_data      (bus.e_data),
      .dst_wr_en   (bus.dst_wr_en),
      .dst_wr_addr (bus.dst_wr_addr),
      .dst_wr_data (bus.dst_wr_data),
      .full        (frame_full)
   );
endmodule

// File: tb/tb_canny_frame_ctrl.sv
// Directed bench for canny_frame_ctrl on an 8x4 frame with an addr=value source RAM
// and a 20-cycle delay line standing in for the edge engine.
module tb_canny_frame_ctrl;

   localparam int WIDTH = 8;
   localparam int ADDR_W = 5;
   localparam int DLY = 20;
   // (V_BLANK + V_RES + FLUSH_LINES) line periods of 12 cycles before DRAIN
   localparam int DRAIN_AT = 96;
   localparam int DONE_AT = 97;
   localparam int ERROR_AT = 196;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic busy, done, error;
   logic [15:0] frame_cnt;
   logic edge_dead = 1'b0;

   int checks = 0;
   int errors = 0;

   bit mon_en = 1'b0;
   int rd_cnt, rd_bad, de_cnt, de_bad, run_len, run_bad, line_cnt, dst_cnt, dst_bad, done_cnt;
   logic [7:0] mon_exp;

   logic [DLY-1:0] de_sr;
   logic [7:0]     data_sr [DLY];

   canny_frame_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

   canny_frame_ctrl #(
      .WIDTH(WIDTH), .H_RES(8), .V_RES(4), .H_BLANK(4), .V_BLANK(1),
      .FLUSH_LINES(3), .ADDR_W(ADDR_W), .TIMEOUT(100)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .busy(busy), .done(done), .error(error), .frame_cnt(frame_cnt),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) bus.src_rd_data <= '0;
      else if (bus.src_rd_en) bus.src_rd_data <= 8'(bus.src_rd_addr);
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         de_sr <= '0;
         for (int i = 0; i < DLY; i++) data_sr[i] <= '0;
      end else begin
         de_sr <= {de_sr[DLY-2:0], bus.c_de};
         data_sr[0] <= bus.c_data;
         for (int i = 1; i < DLY; i++) data_sr[i] <= data_sr[i-1];
      end
   end

   assign bus.e_de    = de_sr[DLY-1] & ~edge_dead;
   assign bus.e_data  = data_sr[DLY-1];
   assign bus.e_vsync = 1'b0;
   assign bus.e_hsync = 1'b0;

   // Records stream and write traffic; expected pixel values are 0..31 then flush zeros
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.src_rd_en) begin
            if (bus.src_rd_addr !== rd_cnt[4:0]) rd_bad++;
            rd_cnt++;
         end
         if (bus.c_de) begin
            mon_exp = (de_cnt < 32) ? de_cnt[7:0] : 8'h00;
            if (bus.c_data !== mon_exp) de_bad++;
            de_cnt++;
            run_len++;
         end else if (run_len != 0) begin
            if (run_len != 8) run_bad++;
            line_cnt++;
            run_len = 0;
         end
         if (bus.dst_wr_en) begin
            if (bus.dst_wr_addr !== dst_cnt[4:0] || bus.dst_wr_data !== dst_cnt[7:0]) dst_bad++;
            dst_cnt++;
         end
         if (done) done_cnt++;
      end
   end

   task automatic clear_mon;
      @(posedge clk);
      rd_cnt = 0; rd_bad = 0; de_cnt = 0; de_bad = 0; run_len = 0; run_bad = 0;
      line_cnt = 0; dst_cnt = 0; dst_bad = 0; done_cnt = 0;
      mon_en = 1'b1;
   endtask

   task automatic pulse_start;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic run_frame(input int restart_at, output bit got_done, output int done_at);
      int n;
      clear_mon();
      pulse_start();
      got_done = 1'b0;
      done_at = -1;
      n = 0;
      while (!got_done && n < 400) begin
         start = (n == restart_at);
         @(negedge clk);
         n++;
         if (done) begin
            got_done = 1'b1;
            done_at = n;
         end
      end
      start = 1'b0;
      repeat (120) @(negedge clk);
      mon_en = 1'b0;
   endtask

   task automatic test_reset;
      logic [49:0] outs;
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      outs = {busy, done, error, frame_cnt, bus.src_rd_en, bus.src_rd_addr, bus.c_vsync, bus.c_hsync,
              bus.c_de, bus.c_data, bus.dst_wr_en, bus.dst_wr_addr, bus.dst_wr_data};
      checks++; if (outs !== '0) begin errors++; $display("[TB] FAIL reset_outs got %h exp 0", outs); end
      rstn = 1'b1;
      pulse_start();
      repeat (5) @(negedge clk);
      checks++; if (bus.c_vsync !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL vblk_active got vsync=%b busy=%b exp 1/1", bus.c_vsync, busy); end
      rstn = 1'b0;
      @(negedge clk);
      outs = {busy, done, error, frame_cnt, bus.src_rd_en, bus.src_rd_addr, bus.c_vsync, bus.c_hsync,
              bus.c_de, bus.c_data, bus.dst_wr_en, bus.dst_wr_addr, bus.dst_wr_data};
      checks++; if (outs !== '0) begin errors++; $display("[TB] FAIL midreset_outs got %h exp 0", outs); end
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL post_reset got busy=%b frame_cnt=%0d exp 0/0", busy, frame_cnt); end
   endtask

   task automatic test_frame;
      bit got;
      int at;
      run_frame(-1, got, at);
      checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL frame_done got %0d exp 1", got); end
      checks++; if (at !== DONE_AT) begin errors++; $display("[TB] FAIL frame_done_cycle got %0d exp %0d", at, DONE_AT); end
      checks++; if (rd_cnt !== 32 || rd_bad !== 0) begin errors++; $display("[TB] FAIL src_reads got %0d bad %0d exp 32 bad 0", rd_cnt, rd_bad); end
      checks++; if (de_cnt !== 56 || de_bad !== 0) begin errors++; $display("[TB] FAIL c_de_beats got %0d bad %0d exp 56 bad 0", de_cnt, de_bad); end
      checks++; if (line_cnt !== 7 || run_bad !== 0) begin errors++; $display("[TB] FAIL c_de_lines got %0d bad %0d exp 7 bad 0", line_cnt, run_bad); end
      checks++; if (dst_cnt !== 32 || dst_bad !== 0) begin errors++; $display("[TB] FAIL dst_writes got %0d bad %0d exp 32 bad 0", dst_cnt, dst_bad); end
      checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL done_pulses got %0d exp 1", done_cnt); end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL frame_cnt got %0d exp 1", frame_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL frame_idle got busy=%b exp 0", busy); end
   endtask

   task automatic test_timeout;
      int n;
      bit saw_done;
      edge_dead = 1'b1;
      pulse_start();
      n = 0;
      saw_done = 1'b0;
      while (error !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
         if (done) saw_done = 1'b1;
      end
      checks++; if (n !== ERROR_AT) begin errors++; $display("[TB] FAIL timeout_cycle got %0d exp %0d (drain at %0d)", n, ERROR_AT, DRAIN_AT); end
      checks++; if (busy !== 1'b0 || saw_done !== 1'b0) begin errors++; $display("[TB] FAIL timeout_idle got busy=%b done_seen=%b exp 0/0", busy, saw_done); end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL timeout_frame_cnt got %0d exp 1", frame_cnt); end
      edge_dead = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL error_sticky got %b exp 1", error); end
   endtask

   task automatic test_error_clear;
      int n;
      pulse_start();
      checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL error_clear got error=%b busy=%b exp 0/1", error, busy); end
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n !== DONE_AT) begin errors++; $display("[TB] FAIL rerun_done_cycle got %0d exp %0d", n, DONE_AT); end
      checks++; if (frame_cnt !== 16'd2) begin errors++; $display("[TB] FAIL rerun_frame_cnt got %0d exp 2", frame_cnt); end
      repeat (30) @(negedge clk);
   endtask

   task automatic test_abort;
      bit got;
      int at;
      pulse_start();
      repeat (28) @(negedge clk);
      checks++; if (bus.src_rd_en !== 1'b1 || bus.c_de !== 1'b1) begin errors++; $display("[TB] FAIL pre_abort got rd_en=%b c_de=%b exp 1/1", bus.src_rd_en, bus.c_de); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++; if ({busy, bus.src_rd_en, bus.c_de, bus.dst_wr_en, done} !== 5'b0) begin errors++; $display("[TB] FAIL abort_outs got %b exp 00000", {busy, bus.src_rd_en, bus.c_de, bus.dst_wr_en, done}); end
      checks++; if (frame_cnt !== 16'd2 || error !== 1'b0) begin errors++; $display("[TB] FAIL abort_status got frame_cnt=%0d error=%b exp 2/0", frame_cnt, error); end
      repeat (40) @(negedge clk);
      run_frame(-1, got, at);
      checks++; if (dst_cnt !== 32 || dst_bad !== 0) begin errors++; $display("[TB] FAIL post_abort_dst got %0d bad %0d exp 32 bad 0", dst_cnt, dst_bad); end
      checks++; if (rd_cnt !== 32 || de_bad !== 0) begin errors++; $display("[TB] FAIL post_abort_stream got %0d bad %0d exp 32 bad 0", rd_cnt, de_bad); end
      checks++; if (done_cnt !== 1 || frame_cnt !== 16'd3) begin errors++; $display("[TB] FAIL post_abort_done got %0d frame_cnt %0d exp 1/3", done_cnt, frame_cnt); end
   endtask

   task automatic test_back_to_back;
      bit got;
      int at;
      run_frame(14, got, at);
      checks++; if (at !== DONE_AT) begin errors++; $display("[TB] FAIL restart_done_cycle got %0d exp %0d", at, DONE_AT); end
      checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL restart_done_pulses got %0d exp 1", done_cnt); end
      checks++; if (frame_cnt !== 16'd4) begin errors++; $display("[TB] FAIL restart_frame_cnt got %0d exp 4", frame_cnt); end
      checks++; if (dst_cnt !== 32 || dst_bad !== 0) begin errors++; $display("[TB] FAIL restart_dst got %0d bad %0d exp 32 bad 0", dst_cnt, dst_bad); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_timeout();
      test_error_clear();
      test_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
